// File: rtl/fifo_ctrl_512.sv
// Pointer and flag controller that turns a 512x8 synchronous dual-port RAM into a FIFO.
// Occupancy is tracked by a registered count; flags decode combinationally from it.
module fifo_ctrl_512 #(
   parameter int ADDR_WIDTH    = 9,
   parameter int DEPTH         = 512,
   parameter int DATA_WIDTH    = 8,
   parameter int AFULL_THRESH  = 480,
   parameter int AEMPTY_THRESH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic                  ram_wr_enb,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_rd_enb,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  error_flag
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = CW'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  push_acc;
   logic                  pop_acc;
   logic                  overflow_next;
   logic                  underflow_next;

   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_CNT);
   assign almost_empty = (count <= AEMPTY_CNT);

   // Gating with full/empty keeps the RAM from ever seeing a same-address read and write.
   assign push_acc = push & ~full & ~rst;
   assign pop_acc  = pop & ~empty & ~rst;

   assign overflow_next  = push & full;
   assign underflow_next = pop & empty;

   assign ram_wr_enb  = push_acc;
   assign ram_wr_addr = wr_ptr;
   assign ram_wr_data = push_data;
   assign ram_rd_enb  = pop_acc;
   assign ram_rd_addr = rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({push_acc, pop_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid   <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         error_flag <= 1'b0;
      end else begin
         rd_valid   <= pop_acc;
         overflow   <= overflow_next;
         underflow  <= underflow_next;
         error_flag <= error_flag | overflow_next | underflow_next;
      end
   end

endmodule
